// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a Uart8 transmitter: buffers host writes and launches one
// frame at a time, holding txIn stable until the UART reports completion.
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 1023,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          wrEn,
  input  logic [7:0]    wrData,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          txErr,
  output logic          txEn,
  output logic          txStart,
  output logic [7:0]    txIn,
  input  logic          txBusy,
  input  logic          txDone
);

  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO   = {(AW + 1){1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtrR;
  logic [AW-1:0] rdPtrR;
  logic [AW:0]   countR;
  logic [AW:0]   countNextS;
  logic          fullR;
  logic          emptyR;
  logic          overflowR;
  logic          txErrR;
  logic          txEnR;
  logic          txStartR;
  logic [7:0]    txInR;
  logic [TW-1:0] timerR;
  logic          sendAgedR;
  state_t        stateR;
  state_t        stateNextS;
  logic          popS;
  logic          wrAcceptS;
  logic          timeoutS;

  assign wrAcceptS  = wrEn & ~fullR;
  assign countNextS = countR + {{AW{1'b0}}, wrAcceptS} - {{AW{1'b0}}, popS};

  // Next-state decode; a pop only ever happens on the IDLE->START load.
  always_comb begin
    stateNextS = stateR;
    popS       = 1'b0;
    timeoutS   = 1'b0;
    case (stateR)
      IDLE: begin
        if (enable && !emptyR) begin
          popS       = 1'b1;
          stateNextS = START;
        end else begin
          stateNextS = IDLE;
        end
      end
      START: begin
        if (txBusy) begin
          stateNextS = SEND;
        end else if (timerR == TIMER_LAST) begin
          timeoutS   = 1'b1;
          stateNextS = IDLE;
        end else begin
          stateNextS = START;
        end
      end
      SEND: begin
        // txBusy low is only trusted once the UART has had a cycle to raise it.
        if (txDone || (!txBusy && sendAgedR)) begin
          stateNextS = IDLE;
        end else begin
          stateNextS = SEND;
        end
      end
      default: begin
        stateNextS = IDLE;
      end
    endcase
  end

  // FIFO storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wrAcceptS) begin
      mem[wrPtrR] <= wrData;
    end
  end

  // Pointers, occupancy flags, sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtrR    <= {AW{1'b0}};
      rdPtrR    <= {AW{1'b0}};
      countR    <= CNT_ZERO;
      fullR     <= 1'b0;
      emptyR    <= 1'b1;
      overflowR <= 1'b0;
      txErrR    <= 1'b0;
      txEnR     <= 1'b0;
      txStartR  <= 1'b0;
      txInR     <= 8'h00;
      timerR    <= {TW{1'b0}};
      sendAgedR <= 1'b0;
      stateR    <= IDLE;
    end else begin
      if (wrAcceptS) begin
        wrPtrR <= wrPtrR + PTR_ONE;
      end
      if (popS) begin
        rdPtrR <= rdPtrR + PTR_ONE;
        txInR  <= mem[rdPtrR];
        timerR <= {TW{1'b0}};
      end else if (stateR == START) begin
        timerR <= timerR + TW'(1);
      end
      countR    <= countNextS;
      fullR     <= (countNextS == CNT_FULL);
      emptyR    <= (countNextS == CNT_ZERO);
      overflowR <= wrEn & fullR;
      txErrR    <= timeoutS;
      stateR    <= stateNextS;
      sendAgedR <= (stateR == SEND) && (stateNextS == SEND);
      txStartR  <= (stateNextS == START);
      txEnR     <= enable | (stateNextS != IDLE);
    end
  end

  assign full     = fullR;
  assign empty    = emptyR;
  assign count    = countR;
  assign overflow = overflowR;
  assign txErr    = txErrR;
  assign txEn     = txEnR;
  assign txStart  = txStartR;
  assign txIn     = txInR;

endmodule
